// File: rtl/score_update_arbiter_if.sv
// Bus between the lane hit judges / game control and the score arbiter.
// Master drives game control and hit strobes; slave returns score state.
interface score_update_arbiter_if #(
  parameter int NUM_LANES = 4,
  parameter int SCORE_W   = 8
);
  logic                   start;
  logic                   stop;
  logic [NUM_LANES-1:0]   hit_vld;
  logic [2*NUM_LANES-1:0] hit_grade;
  logic [SCORE_W-1:0]     score;
  logic [7:0]             combo;
  logic                   sat;
  logic                   drop;
  logic [NUM_LANES-1:0]   pending;
  logic [1:0]             phase;

  modport master (
    output start, stop, hit_vld, hit_grade,
    input  score, combo, sat, drop, pending, phase
  );

  modport slave (
    input  start, stop, hit_vld, hit_grade,
    output score, combo, sat, drop, pending, phase
  );
endinterface

// File: rtl/score_update_arbiter.sv
// Round-robin serialiser of lane hits into one saturating score accumulator.
// Optional macro SCORE_COMBO_BONUS_EN: +1 point on hits whose prior combo >= 10.
module score_update_arbiter #(
  parameter int NUM_LANES   = 4,
  parameter int SCORE_W     = 8,
  parameter int GOOD_PTS    = 1,
  parameter int PERFECT_PTS = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  score_update_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_RUN  = 2'd1,
    PH_HOLD = 2'd2
  } phase_e;

  phase_e                 phase_q;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [7:0]             combo_q, combo_d;
  logic                   sat_q, sat_d;
  logic                   drop_q, drop_d;
  logic [NUM_LANES-1:0]   pending_q, pending_d;
  logic [2*NUM_LANES-1:0] grade_q, grade_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;

  logic                   grant_vld_s;
  logic [PTR_W-1:0]       grant_idx_s;
  int                     lane_s;
  logic [1:0]             gsel_s;
  logic                   hit_s;
  logic [SCORE_W:0]       pts_s;
  logic [SCORE_W:0]       sum_s;

  // Round-robin pick: first pending lane at or above the pointer, wrapping.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    lane_s      = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_s = (int'(ptr_q) + i) % NUM_LANES;
      if (!grant_vld_s && pending_q[lane_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = PTR_W'(lane_s);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Points for the granted lane's buffered grade and the widened sum.
  always_comb begin
    gsel_s = grade_q[int'(grant_idx_s)*2 +: 2];
    pts_s  = '0;
    hit_s  = 1'b0;
    case (gsel_s)
      2'd1: begin
        pts_s = (SCORE_W+1)'(GOOD_PTS);
        hit_s = 1'b1;
      end
      2'd2: begin
        pts_s = (SCORE_W+1)'(PERFECT_PTS);
        hit_s = 1'b1;
      end
      default: begin
        pts_s = '0;
        hit_s = 1'b0;
      end
    endcase
`ifdef SCORE_COMBO_BONUS_EN
    if (hit_s && (combo_q >= 8'd10)) begin
      pts_s = pts_s + (SCORE_W+1)'(1);
    end else begin
      pts_s = pts_s;
    end
`endif
    sum_s = {1'b0, score_q} + pts_s;
  end

  // Next-state for score, combo, lane buffers and pointer.
  always_comb begin
    score_d   = score_q;
    combo_d   = combo_q;
    sat_d     = sat_q;
    pending_d = pending_q;
    grade_d   = grade_q;
    ptr_d     = ptr_q;
    drop_d    = 1'b0;
    if (bus.start) begin
      score_d   = '0;
      combo_d   = 8'd0;
      sat_d     = 1'b0;
      pending_d = '0;
    end else if ((phase_q == PH_RUN) && bus.stop) begin
      pending_d = '0;
    end else if (phase_q == PH_RUN) begin
      if (grant_vld_s) begin
        if (sum_s[SCORE_W]) begin
          score_d = '1;
          sat_d   = 1'b1;
        end else begin
          score_d = sum_s[SCORE_W-1:0];
        end
        if (hit_s) begin
          combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
        end else begin
          combo_d = 8'd0;
        end
        ptr_d = (grant_idx_s == PTR_W'(NUM_LANES - 1)) ? '0 : grant_idx_s + PTR_W'(1);
      end else begin
        ptr_d = ptr_q;
      end
      // A granted lane frees its slot this edge, so a same-cycle hit refills it.
      for (int k = 0; k < NUM_LANES; k++) begin
        if (bus.hit_vld[k] && (!pending_q[k] || (grant_vld_s && (grant_idx_s == PTR_W'(k))))) begin
          pending_d[k]       = 1'b1;
          grade_d[2*k +: 2]  = bus.hit_grade[2*k +: 2];
        end else if (bus.hit_vld[k]) begin
          drop_d = 1'b1;
        end else if (grant_vld_s && (grant_idx_s == PTR_W'(k))) begin
          pending_d[k] = 1'b0;
        end else begin
          pending_d[k] = pending_q[k];
        end
      end
    end else begin
      drop_d = 1'b0;
    end
  end

  // Phase FSM and state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q   <= PH_IDLE;
      score_q   <= '0;
      combo_q   <= 8'd0;
      sat_q     <= 1'b0;
      drop_q    <= 1'b0;
      pending_q <= '0;
      grade_q   <= '0;
      ptr_q     <= '0;
    end else begin
      score_q   <= score_d;
      combo_q   <= combo_d;
      sat_q     <= sat_d;
      drop_q    <= drop_d;
      pending_q <= pending_d;
      grade_q   <= grade_d;
      ptr_q     <= ptr_d;
      case (phase_q)
        PH_IDLE: phase_q <= bus.start ? PH_RUN : PH_IDLE;
        PH_RUN:  phase_q <= bus.start ? PH_RUN : (bus.stop ? PH_HOLD : PH_RUN);
        PH_HOLD: phase_q <= bus.start ? PH_RUN : PH_HOLD;
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  assign bus.score   = score_q;
  assign bus.combo   = combo_q;
  assign bus.sat     = sat_q;
  assign bus.drop    = drop_q;
  assign bus.pending = pending_q;
  assign bus.phase   = phase_q;
endmodule

// File: tb/tb_score_update_arbiter.sv
// Randomised and directed bench for score_update_arbiter with a lane-level
// reference model (integer score, per-lane slots, round-robin pointer).
module tb_score_update_arbiter;
  localparam int NL   = 4;
  localparam int SW   = 8;
  localparam int SMAX = 255;
  localparam int GP   = 1;
  localparam int PP   = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  score_update_arbiter_if #(.NUM_LANES(NL), .SCORE_W(SW)) bus ();

  score_update_arbiter #(
    .NUM_LANES(NL), .SCORE_W(SW), .GOOD_PTS(GP), .PERFECT_PTS(PP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_score, m_combo, m_ptr, m_phase;
  bit m_sat, m_drop;
  bit m_pend[NL];
  int m_grade[NL];

  function automatic logic [NL-1:0] mvec();
    logic [NL-1:0] v;
    for (int k = 0; k < NL; k++) v[k] = m_pend[k];
    return v;
  endfunction

  task automatic model_step();
    int g;
    int pts;
    m_drop = 1'b0;
    if (!rst_n) begin
      m_score = 0; m_combo = 0; m_ptr = 0; m_phase = 0; m_sat = 1'b0;
      for (int k = 0; k < NL; k++) begin m_pend[k] = 1'b0; m_grade[k] = 0; end
      return;
    end
    if (bus.start) begin
      m_score = 0; m_combo = 0; m_sat = 1'b0; m_phase = 1;
      for (int k = 0; k < NL; k++) m_pend[k] = 1'b0;
    end else if (m_phase == 1 && bus.stop) begin
      m_phase = 2;
      for (int k = 0; k < NL; k++) m_pend[k] = 1'b0;
    end else if (m_phase == 1) begin
      g = -1;
      for (int i = 0; i < NL; i++)
        if (g < 0 && m_pend[(m_ptr + i) % NL]) g = (m_ptr + i) % NL;
      if (g >= 0) begin
        pts = (m_grade[g] == 1) ? GP : ((m_grade[g] == 2) ? PP : 0);
`ifdef SCORE_COMBO_BONUS_EN
        if (pts > 0 && m_combo >= 10) pts = pts + 1;
`endif
        if (m_score + pts > SMAX) begin m_score = SMAX; m_sat = 1'b1; end
        else m_score = m_score + pts;
        m_combo = (pts > 0) ? ((m_combo < 255) ? m_combo + 1 : 255) : 0;
        m_pend[g] = 1'b0;
        m_ptr = (g + 1) % NL;
      end
      for (int k = 0; k < NL; k++) begin
        if (bus.hit_vld[k]) begin
          if (!m_pend[k]) begin m_pend[k] = 1'b1; m_grade[k] = int'(bus.hit_grade[2*k +: 2]); end
          else m_drop = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input bit st, input bit sp, input logic [NL-1:0] v, input logic [2*NL-1:0] gr);
    bus.start = st; bus.stop = sp; bus.hit_vld = v; bus.hit_grade = gr;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'b1111, 8'hAA);
    tick();
    tick();
    checks++; if (bus.score !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", bus.score); end
    checks++; if (bus.combo !== 8'd0) begin failures++; $display("FAIL reset_combo got=%0d exp=0", bus.combo); end
    checks++; if (bus.sat !== 1'b0 || bus.drop !== 1'b0) begin failures++; $display("FAIL reset_flags sat=%b drop=%b exp 0 0", bus.sat, bus.drop); end
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL reset_pending got=%b exp=0000", bus.pending); end
    checks++; if (bus.phase !== 2'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", bus.phase); end
  endtask

  task automatic test_first_hit();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 4'b0101, 8'h11);
    tick();
    checks++; if (bus.pending !== 4'b0000 || bus.drop !== 1'b0) begin failures++; $display("FAIL idle_ignore pending=%b drop=%b exp 0000 0", bus.pending, bus.drop); end
    drive(1'b1, 1'b0, '0, '0);
    tick();
    checks++; if (bus.phase !== 2'd1) begin failures++; $display("FAIL start_phase got=%0d exp=1", bus.phase); end
    drive(1'b0, 1'b0, 4'b0001, 8'h02);
    tick();
    checks++; if (bus.pending !== 4'b0001) begin failures++; $display("FAIL first_pending got=%b exp=0001", bus.pending); end
    tick();
    checks++; if (bus.score !== 8'd2 || bus.combo !== 8'd1 || bus.sat !== 1'b0) begin
      failures++; $display("FAIL first_update score=%0d combo=%0d sat=%b exp 2 1 0", bus.score, bus.combo, bus.sat); end
  endtask

  task automatic test_round_robin();
    logic [NL-1:0] ep;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    drive(1'b1, 1'b0, '0, '0); tick();
    drive(1'b0, 1'b0, 4'b1111, 8'h55); tick();
    checks++; if (bus.pending !== 4'b1111) begin failures++; $display("FAIL rr_capture got=%b exp=1111", bus.pending); end
    for (int i = 0; i < NL; i++) begin
      tick();
      ep = 4'b1111 << (i + 1);
      checks++; if (bus.score !== 8'(i + 1) || bus.pending !== ep) begin
        failures++; $display("FAIL rr_grant%0d score=%0d pending=%b exp %0d %b", i, bus.score, bus.pending, i + 1, ep); end
    end
    drive(1'b0, 1'b0, 4'b1001, 8'h41); tick();
    tick();
    checks++; if (bus.score !== 8'd5 || bus.pending !== 4'b1000) begin
      failures++; $display("FAIL rr_wrap score=%0d pending=%b exp 5 1000", bus.score, bus.pending); end
    tick();
  endtask

  task automatic test_drop();
    int base;
    base = m_score;
    drive(1'b0, 1'b0, 4'b0111, 8'h15); tick();
    checks++; if (bus.pending !== 4'b0111) begin failures++; $display("FAIL drop_setup got=%b exp=0111", bus.pending); end
    drive(1'b0, 1'b0, 4'b0100, 8'h10); tick();
    checks++; if (bus.drop !== 1'b1 || bus.pending !== 4'b0110) begin
      failures++; $display("FAIL drop_pulse drop=%b pending=%b exp 1 0110", bus.drop, bus.pending); end
    tick();
    checks++; if (bus.drop !== 1'b0) begin failures++; $display("FAIL drop_oneshot got=%b exp=0", bus.drop); end
    tick();
    checks++; if (bus.score !== 8'(base + 3) || bus.pending !== 4'b0000) begin
      failures++; $display("FAIL drop_total score=%0d pending=%b exp %0d 0000", bus.score, bus.pending, base + 3); end
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, '0, '0); tick();
    while (m_score <= 250) begin drive(1'b0, 1'b0, 4'b0010, 8'h08); tick(); tick(); end
    drive(1'b0, 1'b0, 4'b0010, 8'h00); tick(); tick();
    while (m_score < 254) begin drive(1'b0, 1'b0, 4'b0100, 8'h10); tick(); tick(); end
    checks++; if (bus.score !== 8'd254 || bus.sat !== 1'b0) begin
      failures++; $display("FAIL sat_pre score=%0d sat=%b exp 254 0", bus.score, bus.sat); end
    drive(1'b0, 1'b0, 4'b0001, 8'h02); tick(); tick();
    checks++; if (bus.score !== 8'd255 || bus.sat !== 1'b1) begin
      failures++; $display("FAIL sat_hit score=%0d sat=%b exp 255 1", bus.score, bus.sat); end
    drive(1'b0, 1'b0, 4'b1000, 8'h40); tick(); tick();
    checks++; if (bus.score !== 8'd255 || bus.sat !== 1'b1) begin
      failures++; $display("FAIL sat_sticky score=%0d sat=%b exp 255 1", bus.score, bus.sat); end
    drive(1'b1, 1'b0, '0, '0); tick();
    checks++; if (bus.score !== 8'd0 || bus.sat !== 1'b0) begin
      failures++; $display("FAIL sat_clear score=%0d sat=%b exp 0 0", bus.score, bus.sat); end
  endtask

  task automatic test_combo_stop();
    int g[4] = '{1, 1, 0, 1};
    int ec[4] = '{1, 2, 0, 1};
    logic [7:0] gr;
    drive(1'b1, 1'b0, '0, '0); tick();
    for (int i = 0; i < 4; i++) begin
      gr = 8'(g[i]);
      drive(1'b0, 1'b0, 4'b0001, gr); tick(); tick();
      checks++; if (bus.combo !== 8'(ec[i])) begin failures++; $display("FAIL combo_seq%0d got=%0d exp=%0d", i, bus.combo, ec[i]); end
    end
    checks++; if (bus.score !== 8'd3) begin failures++; $display("FAIL combo_score got=%0d exp=3", bus.score); end
    drive(1'b0, 1'b1, '0, '0); tick();
    drive(1'b0, 1'b0, 4'b0001, 8'h02); tick(); tick();
    checks++; if (bus.phase !== 2'd2 || bus.score !== 8'd3 || bus.pending !== 4'b0000 || bus.drop !== 1'b0) begin
      failures++; $display("FAIL hold_ignore phase=%0d score=%0d pending=%b drop=%b exp 2 3 0000 0", bus.phase, bus.score, bus.pending, bus.drop); end
  endtask

  task automatic test_bonus();
    int exp_s;
`ifdef SCORE_COMBO_BONUS_EN
    exp_s = 12;
`else
    exp_s = 11;
`endif
    drive(1'b1, 1'b0, '0, '0); tick();
    for (int i = 0; i < 11; i++) begin drive(1'b0, 1'b0, 4'b0100, 8'h10); tick(); tick(); end
    checks++; if (bus.score !== 8'(exp_s)) begin failures++; $display("FAIL bonus_score got=%0d exp=%0d", bus.score, exp_s); end
  endtask

  task automatic test_random();
    drive(1'b1, 1'b0, '0, '0); tick();
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 59) == 0),
            4'($urandom) & 4'($urandom | $urandom), 8'($urandom));
      if (m_phase != 1 && $urandom_range(0, 7) == 0) bus.start = 1'b1;
      tick();
      rst_n = 1'b1;
      checks++; if (bus.score !== 8'(m_score) || bus.combo !== 8'(m_combo) || bus.sat !== m_sat) begin
        failures++; $display("FAIL rand_acc c=%0d score=%0d combo=%0d sat=%b exp %0d %0d %b", c, bus.score, bus.combo, bus.sat, m_score, m_combo, m_sat); end
      checks++; if (bus.drop !== m_drop || bus.pending !== mvec() || bus.phase !== 2'(m_phase)) begin
        failures++; $display("FAIL rand_ctl c=%0d drop=%b pending=%b phase=%0d exp %b %b %0d", c, bus.drop, bus.pending, bus.phase, m_drop, mvec(), m_phase); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    #1;
    test_reset();
    test_first_hit();
    test_round_robin();
    test_drop();
    test_saturation();
    test_combo_stop();
    test_bonus();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
